// File: rtl/constantes_estacionamiento_pkg.sv
// Shared constants for the parking controller: clock frequency and the
// default timing values of the sensor front end. The top-level blink logic
// derives its own periods from the same numbers.
package constantes_estacionamiento;

    localparam int CLK_FREQ_HZ = 12_000_000;

    // Converts a duration in milliseconds to clock cycles. The division is
    // done first so that long durations (tens of seconds) stay inside 32 bits.
    function automatic int ms_to_cycles(input int ms);
        return (CLK_FREQ_HZ / 1000) * ms;
    endfunction

    // 20 ms: long enough to ride out contact chatter from the beam sensors.
    localparam int DEBOUNCE_CYCLES_DEFAULT = ms_to_cycles(20);

    // 30 s: no car legitimately blocks a beam this long.
    localparam int STUCK_CYCLES_DEFAULT = ms_to_cycles(30_000);

endpackage

// File: rtl/canal_sensor.sv
// One sensor channel: two-flop synchroniser with inversion, debounce
// counter, clean level flop, registered rising-edge pulse and a saturating
// stuck-active detector. Every output is a flop.
module canal_sensor
    import constantes_estacionamiento::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic stuck
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int SW = $clog2(STUCK_CYCLES + 1);

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SCNT_MAX  = SW'(STUCK_CYCLES);
    localparam logic [SW-1:0] SCNT_PRE  = SW'(STUCK_CYCLES - 1);

    logic          raw_q;
    logic          sync_x;
    logic [DW-1:0] dcnt;
    logic [SW-1:0] scnt;
    logic          accept;
    logic          level_next;

    // Synchroniser: raw is sampled as-is, inversion sits between the flops so
    // both reset to the inactive (beam clear) level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q  <= 1'b1;
            sync_x <= 1'b0;
        end else begin
            // NOTE: raw_q may go metastable; nothing but the second flop may read it.
            raw_q  <= raw;
            sync_x <= ~raw_q;
        end
    end

    // A new level is accepted on the last of DEBOUNCE_CYCLES disagreeing cycles.
    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        accept     = 1'b0;
        level_next = level;
        if ((sync_x != level) && (dcnt == DCNT_LAST)) begin
            accept     = 1'b1;
            level_next = sync_x;
        end
    end

    // Debounce counter, clean level and rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop here samples pre-edge values.
            if (sync_x == level || accept) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
            level <= level_next;
            rise  <= accept & sync_x;
        end
    end

    // Stuck detector: counts while the level stays high, holds at the limit,
    // and clears on the very edge the level drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt  <= '0;
            stuck <= 1'b0;
        end else if (!level_next) begin
            scnt  <= '0;
            stuck <= 1'b0;
        end else if (level) begin
            if (scnt != SCNT_MAX) begin
                scnt <= scnt + 1'b1;
            end
            if (scnt == SCNT_PRE) begin
                stuck <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/acondicionador_sensores.sv
// Sensor front end of the parking controller: conditions the two raw,
// active-low beam sensors into clean levels, rise pulses and stuck faults
// for the entry/exit FSM and the diagnostic LED.
module acondicionador_sensores
    import constantes_estacionamiento::*;
#(
    parameter int CLK_FREQ        = CLK_FREQ_HZ,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int STUCK_CYCLES    = STUCK_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_a_raw,
    input  logic sensor_b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic b_rise,
    output logic fault_a,
    output logic fault_b,
    output logic fault
);

    // Reject parameter sets the counters cannot implement.
    if (CLK_FREQ <= 0 || DEBOUNCE_CYCLES < 2 || STUCK_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
        $error("acondicionador_sensores: illegal CLK_FREQ/DEBOUNCE_CYCLES/STUCK_CYCLES");
    end

    canal_sensor #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_canal_a (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sensor_a_raw),
        .level (a),
        .rise  (a_rise),
        .stuck (fault_a)
    );

    canal_sensor #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_canal_b (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sensor_b_raw),
        .level (b),
        .rise  (b_rise),
        .stuck (fault_b)
    );

    // Combined fault for the LED, registered so it comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else begin
            fault <= fault_a | fault_b;
        end
    end

endmodule
